// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl
//   Memory-stage responder for the decoder's RAM_en / RAM_op requests.
//   It turns one pipeline memory request into a multi-cycle strobe sequence
//   on the board's 16-bit SRAM, or on the UART when the address hits one of
//   the two UART registers. The pipeline is stalled while an access is in
//   flight, and a one-cycle done pulse accompanies the returned read data.
//
// Ports
//   clk_50MHz, rst (sync, active-low)        clock / reset
//   RAM_en, RAM_op, addr, wdata              pipeline request (held until done)
//   rdata, busy, done                        pipeline response / stall
//   sram_addr, sram_dq_i/_o/_oe              SRAM address and shared data bus
//   sram_ce_n, sram_oe_n, sram_we_n          SRAM strobes (active-low)
//   uart_rdn, uart_wrn                       UART strobes (active-low)
//   uart_data_ready, uart_tbre, uart_tsre    UART status lines
module mem_access_ctrl #(
  parameter logic [15:0] UART_DATA_ADDR = 16'hBF00,
  parameter logic [15:0] UART_STAT_ADDR = 16'hBF01
) (
  input  logic        clk_50MHz,
  input  logic        rst,
  input  logic        RAM_en,
  input  logic        RAM_op,
  input  logic [15:0] addr,
  input  logic [15:0] wdata,
  output logic [15:0] rdata,
  output logic        busy,
  output logic        done,
  output logic [17:0] sram_addr,
  input  logic [15:0] sram_dq_i,
  output logic [15:0] sram_dq_o,
  output logic        sram_dq_oe,
  output logic        sram_ce_n,
  output logic        sram_oe_n,
  output logic        sram_we_n,
  output logic        uart_rdn,
  output logic        uart_wrn,
  input  logic        uart_data_ready,
  input  logic        uart_tbre,
  input  logic        uart_tsre
);

  localparam logic RAM_OP_RD = 1'b0;
  localparam logic RAM_OP_WR = 1'b1;

  typedef enum logic [3:0] {
    S_IDLE, S_SRD1, S_SRD2, S_SWR1, S_SWR2, S_SWR3,
    S_URD1, S_URD2, S_UWR1, S_UWR2, S_DONE
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] addr_q, addr_d;
  logic [15:0] wdata_q, wdata_d;
  logic [15:0] rdata_q, rdata_d;
  logic        done_q, done_d;
  logic [15:0] dq_o_q, dq_o_d;
  logic        dq_oe_q, dq_oe_d;
  logic        ce_n_q, ce_n_d;
  logic        oe_n_q, oe_n_d;
  logic        we_n_q, we_n_d;
  logic        rdn_q, rdn_d;
  logic        wrn_q, wrn_d;

  // Next-state, latches and strobe values. Strobes are derived from the
  // next state and registered, so each strobe is glitch-free and valid for
  // the whole cycle its state occupies.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;

    case (state_q)
      S_IDLE: begin
        if (RAM_en) begin
          addr_d  = addr;
          wdata_d = wdata;
          if (addr == UART_STAT_ADDR) begin
            state_d = S_DONE;
            // Status is sampled on the accept edge; a status write is a no-op.
            if (RAM_op == RAM_OP_RD)
              rdata_d = {14'b0, uart_data_ready, uart_tbre & uart_tsre};
          end else if (addr == UART_DATA_ADDR) begin
            state_d = (RAM_op == RAM_OP_WR) ? S_UWR1 : S_URD1;
          end else begin
            state_d = (RAM_op == RAM_OP_WR) ? S_SWR1 : S_SRD1;
          end
        end
      end
      S_SRD1: state_d = S_SRD2;
      S_SRD2: begin
        state_d = S_DONE;
        rdata_d = sram_dq_i;
      end
      S_SWR1: state_d = S_SWR2;
      S_SWR2: state_d = S_SWR3;
      S_SWR3: state_d = S_DONE;
      S_URD1: state_d = S_URD2;
      S_URD2: begin
        state_d = S_DONE;
        // UART data register is byte-wide on the low lanes.
        rdata_d = {8'h00, sram_dq_i[7:0]};
      end
      S_UWR1:  state_d = S_UWR2;
      S_UWR2:  state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // The address bus returns to zero whenever the controller is idle.
    if (state_d == S_IDLE)
      addr_d = 16'h0000;

    dq_oe_d = 1'b0;
    ce_n_d  = 1'b1;
    oe_n_d  = 1'b1;
    we_n_d  = 1'b1;
    rdn_d   = 1'b1;
    wrn_d   = 1'b1;
    case (state_d)
      S_SRD1, S_SRD2: begin
        ce_n_d = 1'b0;
        oe_n_d = 1'b0;
      end
      // SWR1 = setup, SWR2 = write pulse, SWR3 = hold; data driven throughout.
      S_SWR1, S_SWR3: begin
        ce_n_d  = 1'b0;
        dq_oe_d = 1'b1;
      end
      S_SWR2: begin
        ce_n_d  = 1'b0;
        dq_oe_d = 1'b1;
        we_n_d  = 1'b0;
      end
      S_URD1, S_URD2: rdn_d = 1'b0;
      S_UWR1: begin
        dq_oe_d = 1'b1;
        wrn_d   = 1'b0;
      end
      S_UWR2:  dq_oe_d = 1'b1;
      default: ;
    endcase

    done_d = (state_d == S_DONE);
    dq_o_d = dq_oe_d ? wdata_d : 16'h0000;
  end

  always_ff @(posedge clk_50MHz) begin
    if (!rst) begin
      state_q <= S_IDLE;
      addr_q  <= 16'h0000;
      wdata_q <= 16'h0000;
      rdata_q <= 16'h0000;
      done_q  <= 1'b0;
      dq_o_q  <= 16'h0000;
      dq_oe_q <= 1'b0;
      ce_n_q  <= 1'b1;
      oe_n_q  <= 1'b1;
      we_n_q  <= 1'b1;
      rdn_q   <= 1'b1;
      wrn_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      done_q  <= done_d;
      dq_o_q  <= dq_o_d;
      dq_oe_q <= dq_oe_d;
      ce_n_q  <= ce_n_d;
      oe_n_q  <= oe_n_d;
      we_n_q  <= we_n_d;
      rdn_q   <= rdn_d;
      wrn_q   <= wrn_d;
    end
  end

  // Stall is gated by reset so a request held across reset does not stall.
  // It drops in DONE so the pipeline advances on the edge leaving DONE.
  assign busy = rst & ((RAM_en & (state_q == S_IDLE)) |
                       ((state_q != S_IDLE) & (state_q != S_DONE)));

  assign rdata      = rdata_q;
  assign done       = done_q;
  assign sram_addr  = {2'b00, addr_q};
  assign sram_dq_o  = dq_o_q;
  assign sram_dq_oe = dq_oe_q;
  assign sram_ce_n  = ce_n_q;
  assign sram_oe_n  = oe_n_q;
  assign sram_we_n  = we_n_q;
  assign uart_rdn   = rdn_q;
  assign uart_wrn   = wrn_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
module tb_mem_access_ctrl;

  logic        clk_50MHz = 1'b0;
  logic        rst = 1'b0;
  logic        RAM_en = 1'b0;
  logic        RAM_op = 1'b0;
  logic [15:0] addr = 16'h0000;
  logic [15:0] wdata = 16'h0000;
  logic [15:0] rdata;
  logic        busy, done;
  logic [17:0] sram_addr;
  logic [15:0] sram_dq_i;
  logic [15:0] sram_dq_o;
  logic        sram_dq_oe, sram_ce_n, sram_oe_n, sram_we_n;
  logic        uart_rdn, uart_wrn;
  logic        uart_data_ready = 1'b0, uart_tbre = 1'b0, uart_tsre = 1'b0;

  logic [15:0] uart_bus = 16'h0000;
  logic [15:0] dev_mem [0:65535];   // SRAM device model (written from pins)
  logic [15:0] sb_mem  [0:65535];   // transaction-level scoreboard
  logic [15:0] last_rdata = 16'h0000;

  int checks = 0;
  int errors = 0;
  int contention = 0;
  int txn_id = 0;

  localparam logic [15:0] DATA_A = 16'hBF00;
  localparam logic [15:0] STAT_A = 16'hBF01;

  mem_access_ctrl dut (
    .clk_50MHz(clk_50MHz), .rst(rst), .RAM_en(RAM_en), .RAM_op(RAM_op),
    .addr(addr), .wdata(wdata), .rdata(rdata), .busy(busy), .done(done),
    .sram_addr(sram_addr), .sram_dq_i(sram_dq_i), .sram_dq_o(sram_dq_o),
    .sram_dq_oe(sram_dq_oe), .sram_ce_n(sram_ce_n), .sram_oe_n(sram_oe_n),
    .sram_we_n(sram_we_n), .uart_rdn(uart_rdn), .uart_wrn(uart_wrn),
    .uart_data_ready(uart_data_ready), .uart_tbre(uart_tbre), .uart_tsre(uart_tsre)
  );

  always #10 clk_50MHz = ~clk_50MHz;

  // Bus devices: SRAM answers while selected and output-enabled, UART while rdn low.
  always_comb begin
    if (!sram_ce_n && !sram_oe_n)
      sram_dq_i = dev_mem[sram_addr[15:0]];
    else if (!uart_rdn)
      sram_dq_i = uart_bus;
    else
      sram_dq_i = 16'hA5C3;
  end

  always @(posedge clk_50MHz)
    if (!sram_ce_n && !sram_we_n && sram_dq_oe)
      dev_mem[sram_addr[15:0]] <= sram_dq_o;

  always @(negedge clk_50MHz)
    if (rst && ((sram_dq_oe && (!sram_oe_n || !uart_rdn)) || (!uart_rdn && !uart_wrn)))
      contention++;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL txn%0d %s: got %h expected %h", txn_id, nm, act, exp);
    end
  endtask

  // Reference model: latency and returned data from the address class rules.
  function automatic int model_n(input logic op, input logic [15:0] a);
    if (a == STAT_A) return 1;
    if (a == DATA_A) return 3;
    return op ? 4 : 3;
  endfunction

  function automatic logic [15:0] model_rd(input logic op, input logic [15:0] a,
      input logic [15:0] bus, input logic dr, input logic tb, input logic ts);
    if (op) return last_rdata;
    if (a == STAT_A) return {14'b0, dr, tb & ts};
    if (a == DATA_A) return {8'h00, bus[7:0]};
    return sb_mem[a];
  endfunction

  task automatic run_txn(input logic op, input logic [15:0] a, input logic [15:0] wd,
      input logic [15:0] bus, input logic dr, input logic tb, input logic ts,
      input logic [15:0] exp_rd, input int exp_n, input logic from_done);
    logic is_stat, is_uart, is_sram, busy_at_done, ce_exp;
    int we_cnt, oe_cnt, rdn_cnt, wrn_cnt, we_at, n_seen;
    int bad_ce, bad_busy, bad_addr, bad_dqo;
    is_stat = (a == STAT_A);
    is_uart = (a == DATA_A);
    is_sram = !is_stat && !is_uart;
    we_cnt = 0; oe_cnt = 0; rdn_cnt = 0; wrn_cnt = 0; we_at = 0; n_seen = 0;
    bad_ce = 0; bad_busy = 0; bad_addr = 0; bad_dqo = 0; busy_at_done = 1'b1;
    txn_id++;
    RAM_en = 1'b1; RAM_op = op; addr = a; wdata = wd; uart_bus = bus;
    uart_data_ready = dr; uart_tbre = tb; uart_tsre = ts;
    if (from_done) begin
      @(posedge clk_50MHz);
      @(negedge clk_50MHz);
      chk("b2b_idle_done", {31'b0, done}, 32'd0);
    end
    #1 chk("busy_on_request", {31'b0, busy}, 32'd1);
    @(posedge clk_50MHz);  // accept edge
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk_50MHz);
      if (sram_addr !== {2'b00, a}) bad_addr++;
      if (sram_dq_oe && (sram_dq_o !== wd)) bad_dqo++;
      if (!sram_we_n) begin we_cnt++; we_at = k; end
      if (!sram_oe_n) oe_cnt++;
      if (!uart_rdn) rdn_cnt++;
      if (!uart_wrn) wrn_cnt++;
      ce_exp = done ? 1'b1 : !is_sram;
      if (sram_ce_n !== ce_exp) bad_ce++;
      if (k == 1) begin
        // Request fields changing after accept must be ignored.
        addr = 16'($urandom); wdata = 16'($urandom); RAM_op = ~op;
        uart_data_ready = ~dr; uart_tbre = ~tb; uart_tsre = ~ts;
      end
      if (done) begin
        n_seen = k;
        busy_at_done = busy;
        break;
      end
      if (!busy) bad_busy++;
    end
    chk("latency", n_seen, exp_n);
    chk("rdata", {16'h0, rdata}, {16'h0, exp_rd});
    chk("busy_in_done", {31'b0, busy_at_done}, 32'd0);
    chk("we_pulses", we_cnt, (is_sram && op) ? 1 : 0);
    chk("we_cycle", we_at, (is_sram && op) ? 2 : 0);
    chk("oe_cycles", oe_cnt, (is_sram && !op) ? 2 : 0);
    chk("rdn_cycles", rdn_cnt, (is_uart && !op) ? 2 : 0);
    chk("wrn_cycles", wrn_cnt, (is_uart && op) ? 1 : 0);
    chk("ce_pattern", bad_ce, 0);
    chk("busy_stall", bad_busy, 0);
    chk("addr_held", bad_addr, 0);
    chk("dq_o_data", bad_dqo, 0);
    $display("txn %0d op=%0d addr=%h wdata=%h rdata=%h exp=%h done_cycle=%0d",
             txn_id, op, a, wd, rdata, exp_rd, n_seen);
    last_rdata = exp_rd;
    if (is_sram && op) sb_mem[a] = wd;
  endtask

  task automatic idle_step();
    RAM_en = 1'b0;
    @(negedge clk_50MHz);
    chk("idle_done", {31'b0, done}, 32'd0);
    chk("idle_busy", {31'b0, busy}, 32'd0);
    chk("idle_strobes", {26'b0, sram_ce_n, sram_oe_n, sram_we_n, uart_rdn, uart_wrn, sram_dq_oe},
        {26'b0, 6'b111110});
    chk("idle_addr", {14'b0, sram_addr}, 32'd0);
    chk("idle_dq_o", {16'b0, sram_dq_o}, 32'd0);
    chk("idle_rdata_hold", {16'b0, rdata}, {16'b0, last_rdata});
  endtask

  typedef struct {
    logic        op;
    logic [15:0] a, wd, bus;
    logic        dr, tb, ts;
    logic [15:0] exp_rd;
    int          exp_n;
    logic        b2b;
  } vec_t;

  localparam int NV = 10;
  vec_t tbl [NV];

  initial begin
    logic b2b;
    logic op, dr, tb, ts;
    logic [15:0] a, wd, bus;
    int cls, dn;

    for (int i = 0; i < 65536; i++) begin
      dev_mem[i] = 16'h0000;
      sb_mem[i]  = 16'h0000;
    end

    //            op    addr      wdata     bus       dr    tb    ts    rdata     N  b2b
    tbl[0] = '{1'b1, 16'h1234, 16'hBEEF, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000, 4, 1'b0};
    tbl[1] = '{1'b0, 16'h1234, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0, 16'hBEEF, 3, 1'b0};
    tbl[2] = '{1'b1, DATA_A,   16'h0041, 16'h0000, 1'b0, 1'b0, 1'b0, 16'hBEEF, 3, 1'b0};
    tbl[3] = '{1'b0, DATA_A,   16'h0000, 16'hFF5A, 1'b0, 1'b0, 1'b0, 16'h005A, 3, 1'b0};
    tbl[4] = '{1'b0, STAT_A,   16'h0000, 16'h0000, 1'b1, 1'b1, 1'b0, 16'h0002, 1, 1'b0};
    tbl[5] = '{1'b1, STAT_A,   16'h7777, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0002, 1, 1'b0};
    tbl[6] = '{1'b0, STAT_A,   16'h0000, 16'h0000, 1'b0, 1'b1, 1'b1, 16'h0001, 1, 1'b0};
    tbl[7] = '{1'b1, 16'h1235, 16'hCAFE, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0001, 4, 1'b0};
    tbl[8] = '{1'b0, 16'h1234, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0, 16'hBEEF, 3, 1'b1};
    tbl[9] = '{1'b0, 16'h1235, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0, 16'hCAFE, 3, 1'b1};

    // Reset held for 3 cycles with a request pending.
    rst = 1'b0; RAM_en = 1'b1; RAM_op = 1'b1; addr = 16'h1234; wdata = 16'hBEEF;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk_50MHz);
      chk("rst_busy", {31'b0, busy}, 32'd0);
      chk("rst_done", {31'b0, done}, 32'd0);
      chk("rst_strobes", {26'b0, sram_ce_n, sram_oe_n, sram_we_n, uart_rdn, uart_wrn, sram_dq_oe},
          {26'b0, 6'b111110});
    end
    chk("rst_rdata", {16'b0, rdata}, 32'd0);
    chk("rst_addr", {14'b0, sram_addr}, 32'd0);
    chk("rst_dq_o", {16'b0, sram_dq_o}, 32'd0);
    RAM_en = 1'b0;
    rst = 1'b1;
    @(negedge clk_50MHz);

    // Directed table.
    for (int i = 0; i < NV; i++) begin
      run_txn(tbl[i].op, tbl[i].a, tbl[i].wd, tbl[i].bus, tbl[i].dr, tbl[i].tb, tbl[i].ts,
              tbl[i].exp_rd, tbl[i].exp_n, tbl[i].b2b);
      if (!(i + 1 < NV && tbl[i + 1].b2b)) idle_step();
    end

    // Randomized traffic against the reference model.
    b2b = 1'b0;
    for (int r = 0; r < 40; r++) begin
      cls = $urandom_range(0, 3);
      op  = 1'($urandom_range(0, 1));
      if (cls <= 1)      a = 16'h0100 + 16'($urandom_range(0, 15));
      else if (cls == 2) a = DATA_A;
      else               a = STAT_A;
      wd  = 16'($urandom);
      bus = 16'($urandom);
      dr  = 1'($urandom_range(0, 1));
      tb  = 1'($urandom_range(0, 1));
      ts  = 1'($urandom_range(0, 1));
      dn  = model_n(op, a);
      run_txn(op, a, wd, bus, dr, tb, ts, model_rd(op, a, bus, dr, tb, ts), dn, b2b);
      b2b = ($urandom_range(0, 3) == 0);
      if (!b2b) idle_step();
    end
    if (b2b) idle_step();

    // Reset while the write strobe is low.
    txn_id++;
    RAM_en = 1'b1; RAM_op = 1'b1; addr = 16'h0200; wdata = 16'h1111;
    @(posedge clk_50MHz);
    @(negedge clk_50MHz);
    chk("swr1_we_high", {31'b0, sram_we_n}, 32'd1);
    @(negedge clk_50MHz);
    chk("swr2_we_low", {31'b0, sram_we_n}, 32'd0);
    rst = 1'b0; RAM_en = 1'b0;
    @(negedge clk_50MHz);
    chk("rst_mid_strobes", {26'b0, sram_ce_n, sram_oe_n, sram_we_n, uart_rdn, uart_wrn, sram_dq_oe},
        {26'b0, 6'b111110});
    chk("rst_mid_done", {31'b0, done}, 32'd0);
    chk("rst_mid_rdata", {16'b0, rdata}, 32'd0);
    rst = 1'b1;
    last_rdata = 16'h0000;
    dn = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk_50MHz);
      if (done || !sram_ce_n || !sram_we_n) dn++;
    end
    chk("rst_mid_no_resume", dn, 0);
    $display("txn %0d reset during write pulse, abandoned", txn_id);

    chk("bus_contention", contention, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_access_ctrl.md
# mem_access_ctrl

Memory-stage responder for the `RAM_en` / `RAM_op` requests produced by the instruction decoder. It turns one pipeline memory request (LW, LW_SP, SW, SW_SP, SW_RS) into a multi-cycle strobe sequence on the board's 16-bit SRAM. Two addresses are mapped to the UART instead, which shares the SRAM data bus. While an access is in flight it stalls the pipeline, and it returns read data with a one-cycle `done` pulse.

## Interface
- `UART_DATA_ADDR`, default 16'hBF00: UART data register address.
- `UART_STAT_ADDR`, default 16'hBF01: UART status register address (read-only).
- `clk_50MHz`  in  1  system clock; all state changes on the rising edge.
- `rst`  in  1  reset, synchronous, active-low.
- `RAM_en`  in  1  request valid; held high by the pipeline until `done`.
- `RAM_op`  in  1  `RAM_OP_RD` (1'b0) = read, `RAM_OP_WR` (1'b1) = write.
- `addr`  in  16  word address (ALU result).
- `wdata`  in  16  store data.
- `rdata`  out  16  load data; valid while `done`=1 and held until the next capture.
- `busy`  out  1  pipeline stall.
- `done`  out  1  one-cycle completion pulse.
- `sram_addr`  out  18  {2'b00, latched addr}.
- `sram_dq_i`  in  16  shared data bus input.
- `sram_dq_o`  out  16  shared data bus output value.
- `sram_dq_oe`  out  1  bus drive enable; 1 = drive `sram_dq_o`.
- `sram_ce_n`, `sram_oe_n`, `sram_we_n`  out  1 each  SRAM strobes, active-low.
- `uart_rdn`, `uart_wrn`  out  1 each  UART strobes, active-low.
- `uart_data_ready`, `uart_tbre`, `uart_tsre`  in  1 each  UART status lines.

## Operation
- **States:** IDLE, SRD1, SRD2, SWR1, SWR2, SWR3, URD1, URD2, UWR1, UWR2, DONE.
- **Accept:** in IDLE, `RAM_en`=1 latches `addr`, `wdata` and `RAM_op`. The latched address class selects the path:
  - SRAM read: IDLE → SRD1 → SRD2 → DONE.
  - SRAM write: IDLE → SWR1 → SWR2 → SWR3 → DONE.
  - UART data read (`addr`=`UART_DATA_ADDR`): IDLE → URD1 → URD2 → DONE.
  - UART data write (`addr`=`UART_DATA_ADDR`): IDLE → UWR1 → UWR2 → DONE.
  - Status read (`addr`=`UART_STAT_ADDR`): IDLE → DONE. `rdata` = {14'b0, `uart_data_ready`, `uart_tbre` & `uart_tsre`}, sampled on the accept edge.
  - Status write (`addr`=`UART_STAT_ADDR`): IDLE → DONE; no strobe, no bus drive.
- **SRD1/SRD2:** `sram_ce_n`=0, `sram_oe_n`=0, `sram_dq_oe`=0. `rdata` ← `sram_dq_i` on the SRD2→DONE edge.
- **SWR1:** `sram_ce_n`=0, `sram_dq_oe`=1, `sram_we_n`=1 (setup).
- **SWR2:** `sram_we_n`=0.
- **SWR3:** `sram_we_n`=1, data still driven (hold).
- **URD1/URD2:** `sram_ce_n`=1, `uart_rdn`=0, `sram_dq_oe`=0. `rdata` ← {8'h00, `sram_dq_i[7:0]`} on the URD2→DONE edge.
- **UWR1:** `sram_ce_n`=1, `sram_dq_oe`=1, `uart_wrn`=0.
- **UWR2:** `uart_wrn`=1, data still driven.
- **DONE:** `done`=1, all strobes inactive, `sram_dq_oe`=0, then unconditionally → IDLE. A request present in the following IDLE cycle is treated as a new request.
- **Strobe/bus rules:**
  - `sram_dq_o` = latched `wdata` whenever `sram_dq_oe`=1.
  - `sram_dq_oe` is never 1 in the same cycle as `sram_oe_n`=0 or `uart_rdn`=0.
  - `uart_rdn` and `uart_wrn` are never low together.
- All strobe outputs are registered (glitch-free). `busy` is combinational.

## Timing
- **Reset** (`rst`=0 at a rising edge): state=IDLE; `rdata`=16'h0000; `done`=0; `sram_addr`=0; `sram_dq_o`=0; `sram_dq_oe`=0; `sram_ce_n`=`sram_oe_n`=`sram_we_n`=1; `uart_rdn`=`uart_wrn`=1.
- **Reset mid-operation:** the access is abandoned and all strobes are inactive from the next edge. No partial write completes after that edge.
- **`busy`** = (`RAM_en` & state==IDLE) | (state ∉ {IDLE, DONE}). It is low in DONE so the pipeline advances on the same edge that leaves DONE.
- **Latency:** accept edge = cycle 0; `done` is high during cycle N:
  - SRAM read: N=3.
  - SRAM write: N=4.
  - UART read: N=3.
  - UART write: N=3.
  - Status access: N=1.
- `RAM_op`, `addr` and `wdata` changes after accept are ignored.
- `RAM_en`=0 in IDLE: outputs stay at reset values, except `rdata`, which holds its last value.

## Test plan
- Reset with `RAM_en`=1: hold `rst`=0 for 3 cycles → all outputs at reset values, `busy`=0 throughout, no strobe.
- SRAM write then read: write `addr`=16'h1234, `wdata`=16'hBEEF → `sram_we_n` low for exactly 1 cycle (cycle 2), `sram_addr`=18'h01234, `done` at cycle 4. Then read with the bench model returning 16'hBEEF → `rdata`=16'hBEEF at cycle 3, `sram_dq_oe`=0 throughout the read.
- UART write/read: write 16'h0041 to 16'hBF00 → `uart_wrn` low 1 cycle, `sram_ce_n`=1, `done` at cycle 3. Read with bus = 16'hFF5A → `rdata`=16'h005A.
- Status read: `uart_data_ready`=1, `uart_tbre`=1, `uart_tsre`=0 → `rdata`=16'h0002, `done` at cycle 1. A status write asserts no strobe and completes at cycle 1.
- Back-to-back: `RAM_en` held high across two reads → second request accepted the cycle after DONE; `busy` low only in the DONE cycles.
- Reset in SWR2: `sram_we_n` returns to 1 on the reset edge, state=IDLE, `done` never pulses; the bus checker flags no contention in any scenario.
